// File: rtl/divider_const_arbiter_pkg.sv
// Shared constants for the constant-divisor datapath: default widths and
// reciprocal/divisor pairs for the default BWI2 shift.
package divider_const_arbiter_pkg;

  localparam int unsigned DEF_BWI1 = 5;
  localparam int unsigned DEF_BWI2 = 10;
  localparam int unsigned DEF_BWO1 = 5;

  // Reciprocal constants are ceil(2^BWI2 / DIVISOR) for BWI2 = 10
  localparam int unsigned DIVISOR_22     = 22;
  localparam int unsigned CONST_MULTI_22 = 47;
  localparam int unsigned DIVISOR_12     = 12;
  localparam int unsigned CONST_MULTI_12 = 86;

  function automatic int unsigned calc_const_multi(input int unsigned bwi2,
                                                   input int unsigned divisor);
    return ((32'd1 << bwi2) + divisor - 1) / divisor;
  endfunction

endpackage

// File: rtl/divider_const_core.sv
// Combinational constant divider: multiply by the reciprocal, shift, then
// recover the remainder from the quotient.
module divider_const_core #(
  parameter int unsigned BWI1        = 5,
  parameter int unsigned BWI2        = 10,
  parameter int unsigned BWO1        = 5,
  parameter int unsigned CONST_MULTI = 47,
  parameter int unsigned DIVISOR     = 22
) (
  input  logic [BWI1-1:0] dividend,
  output logic [BWO1-1:0] quot,
  output logic [BWI1-1:0] rem
);

  localparam int unsigned PW = BWI1 + BWI2 + 1;

  logic [PW-1:0] prod;
  logic [PW-1:0] back;

  always_comb begin
    prod = PW'(dividend) * PW'(CONST_MULTI);
    quot = BWO1'(prod >> BWI2);
    back = PW'(quot) * PW'(DIVISOR);
    rem  = BWI1'(PW'(dividend) - back);
  end

endmodule

// File: rtl/divider_const_arbiter.sv
// Round-robin front end sharing one constant divider among NREQ requesters,
// followed by a two-stage valid/ready pipeline with full backpressure.
module divider_const_arbiter
  import divider_const_arbiter_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned IDW         = 2,
  parameter int unsigned BWI1        = DEF_BWI1,
  parameter int unsigned BWI2        = DEF_BWI2,
  parameter int unsigned BWO1        = DEF_BWO1,
  parameter int unsigned DIVISOR     = DIVISOR_22,
  parameter int unsigned CONST_MULTI = CONST_MULTI_22
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*BWI1-1:0] req_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BWO1-1:0]      out_quot,
  output logic [BWI1-1:0]      out_rem,
  output logic [IDW-1:0]       out_id
);

  logic            s1_valid_q, s2_valid_q;
  logic [BWI1-1:0] s1_data_q;
  logic [IDW-1:0]  s1_id_q;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [BWO1-1:0] quot_q, core_quot;
  logic [BWI1-1:0] rem_q, core_rem;
  logic [IDW-1:0]  id_q;

  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic            s1_adv, s2_adv, accept;
  logic [BWI1-1:0] sel_data;

  // Scan from the pointer, wrapping modulo NREQ; first valid wins
  always_comb begin
    int unsigned idx;
    logic [IDW-1:0] cand;
    idx     = 0;
    cand    = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    s2_adv    = !s2_valid_q || out_ready;
    s1_adv    = !s1_valid_q || s2_adv;
    accept    = gnt_any && s1_adv && !rst;
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
    sel_data  = req_data[32'(gnt_idx)*BWI1 +: BWI1];
    ptr_d     = ptr_q;
    if (accept) ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  divider_const_core #(
    .BWI1       (BWI1),
    .BWI2       (BWI2),
    .BWO1       (BWO1),
    .CONST_MULTI(CONST_MULTI),
    .DIVISOR    (DIVISOR)
  ) u_core (
    .dividend(s1_data_q),
    .quot    (core_quot),
    .rem     (core_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      id_q       <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (s1_adv) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_data_q <= sel_data;
          s1_id_q   <= gnt_idx;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        // Output data only moves when a real result arrives
        if (s1_valid_q) begin
          quot_q <= core_quot;
          rem_q  <= core_rem;
          id_q   <= s1_id_q;
        end
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_quot  = quot_q;
  assign out_rem   = rem_q;
  assign out_id    = id_q;

endmodule

// File: tb/tb_divider_const_arbiter.sv
// Bench for divider_const_arbiter: occupancy/round-robin scoreboard model
// checked every cycle, plus directed literal checks.
module tb_divider_const_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int BWI1 = 5;
  localparam int BWO1 = 5;
  localparam int DIV  = 22;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*BWI1-1:0] req_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [BWO1-1:0]      out_quot;
  logic [BWI1-1:0]      out_rem;
  logic [IDW-1:0]       out_id;

  always #5 clk = ~clk;

  divider_const_arbiter #(
    .NREQ       (NREQ),
    .IDW        (IDW),
    .BWI1       (BWI1),
    .BWI2       (10),
    .BWO1       (BWO1),
    .DIVISOR    (DIV),
    .CONST_MULTI(47)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_quot (out_quot),
    .out_rem  (out_rem),
    .out_id   (out_id)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    int id;
    int quot;
    int rem;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   acc_log[$];
  int   mptr = 0;
  int   cyc  = 0;

  // Model: occupancy-based acceptance, round-robin choice, in-order results
  always @(negedge clk) begin
    int  g;
    int  d;
    int  exp_rdy;
    bit  any;
    bit  acc;
    bit  exp_ov;
    if (rst) begin
      check("rst_req_ready", int'(req_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      sb.delete();
      mptr = 0;
    end else begin
      any = 1'b0;
      g   = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!any && req_valid[(mptr + k) % NREQ]) begin
          any = 1'b1;
          g   = (mptr + k) % NREQ;
        end
      end
      acc     = any && (sb.size() < 2 || out_ready);
      exp_rdy = acc ? (1 << g) : 0;
      check("req_ready", int'(req_ready), exp_rdy);
      exp_ov = (sb.size() > 0) && (cyc >= sb[0].cyc + 2);
      check("out_valid", int'(out_valid), int'(exp_ov));
      if (out_valid && exp_ov) begin
        check("out_quot", int'(out_quot), sb[0].quot);
        check("out_rem", int'(out_rem), sb[0].rem);
        check("out_id", int'(out_id), sb[0].id);
      end
      if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
      if (acc) begin
        d = int'(req_data[g*BWI1 +: BWI1]);
        sb.push_back('{g, d / DIV, d % DIV, cyc});
        mptr = (g + 1) % NREQ;
      end
      for (int k = 0; k < NREQ; k++) begin
        if (req_valid[k] && req_ready[k]) acc_log.push_back(k);
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input int d);
    int n;
    n = 0;
    req_data[id*BWI1 +: BWI1] = BWI1'(d);
    req_valid[id] = 1'b1;
    #1;
    while (!req_ready[id] && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("send_timeout", 0, 1);
    tick();
    req_valid[id] = 1'b0;
  endtask

  task automatic single(input int id, input int d, input int eq, input int er);
    send(id, d);
    tick();
    check("lit_valid", int'(out_valid), 1);
    check("lit_quot", int'(out_quot), eq);
    check("lit_rem", int'(out_rem), er);
    check("lit_id", int'(out_id), id);
    tick();
  endtask

  initial begin
    int exp_order[8];
    int cap_q, cap_r, cap_i;
    bit found;
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};

    repeat (2) tick();
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_quot", int'(out_quot), 0);
    check("reset_rem", int'(out_rem), 0);
    check("reset_id", int'(out_id), 0);
    rst = 1'b0;
    tick();

    // Directed literal results, two-cycle latency
    single(0, 23, 1, 1);
    single(0, 21, 0, 21);
    single(1, 31, 1, 9);
    single(2, 22, 1, 0);
    single(3, 0, 0, 0);

    // Every dividend on every requester, back to back
    for (int id = 0; id < NREQ; id++) begin
      for (int d = 0; d < 32; d++) send(id, d);
    end
    repeat (3) tick();

    // Contention from reset: strict rotation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    acc_log.delete();
    for (int i = 0; i < NREQ; i++) req_data[i*BWI1 +: BWI1] = BWI1'(i * 7 + 3);
    req_valid = '1;
    repeat (8) tick();
    req_valid = '0;
    check("contention_count", acc_log.size(), 8);
    for (int i = 0; i < 8 && i < acc_log.size(); i++) check("grant_order", acc_log[i], exp_order[i]);
    repeat (3) tick();

    // Backpressure: only two entries fit, outputs frozen
    out_ready = 1'b0;
    acc_log.delete();
    req_valid = 4'b0101;
    repeat (2) tick();
    cap_q = int'(out_quot);
    cap_r = int'(out_rem);
    cap_i = int'(out_id);
    repeat (3) tick();
    check("bp_out_valid", int'(out_valid), 1);
    check("bp_quot_stable", int'(out_quot), cap_q);
    check("bp_rem_stable", int'(out_rem), cap_r);
    check("bp_id_stable", int'(out_id), cap_i);
    check("bp_req_ready", int'(req_ready), 0);
    check("bp_accepts", acc_log.size(), 2);
    out_ready = 1'b1;
    tick();
    req_valid = '0;
    repeat (4) tick();

    // Fairness: req0 always valid, req2 must win within NREQ accepts
    req_data[0 +: BWI1] = BWI1'(5);
    req_valid = 4'b0001;
    tick();
    req_data[2*BWI1 +: BWI1] = BWI1'(29);
    req_valid[2] = 1'b1;
    acc_log.delete();
    found = 1'b0;
    for (int i = 0; i < 2 * NREQ && !found; i++) begin
      tick();
      foreach (acc_log[j]) if (acc_log[j] == 2) found = 1'b1;
      if (found) req_valid[2] = 1'b0;
    end
    check("fair_granted", int'(found), 1);
    check("fair_within", int'(acc_log.size() <= NREQ), 1);
    req_valid = '0;
    repeat (4) tick();

    // Reset mid-flight with both stages full
    out_ready = 1'b0;
    req_valid = 4'b0011;
    repeat (2) tick();
    check("pre_rst_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("rst_drop_valid", int'(out_valid), 0);
    check("rst_drop_ready", int'(req_ready), 0);
    req_valid = 4'b1010;
    tick();
    rst = 1'b0;
    acc_log.delete();
    tick();
    check("post_rst_count", acc_log.size(), 1);
    if (acc_log.size() > 0) check("post_rst_grant", acc_log[0], 1);
    req_valid = '0;
    out_ready = 1'b1;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
